bnn_conv_engine: RTL and testbench

Multi-output-channel binary 3x3-class convolution engine for the BNN datapath. It is the next-generation convolution core: parametrised in kernel size, input and output channel count, and accumulator width, with a start/valid/ready handshake and optional per-channel thresholds. All output pixels of one output channel are computed in parallel, one input channel per cycle, with output channels processed sequentially. It sits between the binarised image/feature buffer and the next pooling or fully-connected stage.

---
 rtl/bnn_conv_engine.sv | 128 ++++++++++++
 tb/tb_bnn_conv_engine.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bnn_conv_engine.sv
// Binary KxK convolution engine: every output pixel of one output channel in parallel,
// one input channel per cycle. Define CONV_THRESHOLD_EN to binarise against per-oc thresholds.
module bnn_conv_engine #(
  parameter int unsigned IC           = 8,
  parameter int unsigned OC           = 4,
  parameter int unsigned IMG_IN_SIZE  = 30,
  parameter int unsigned K            = 3,
  parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE - K + 1,
  parameter int unsigned ACC_W        = $clog2(IC * K * K + 1) + 1
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [IC-1:0][IMG_IN_SIZE*IMG_IN_SIZE-1:0]    img_in,
  input  logic [OC*IC*K*K-1:0]                          weights,
  input  logic [OC*ACC_W-1:0]                           thresholds,
  output logic                                          busy,
  output logic [OC-1:0][IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]  img_out,
  output logic                                          out_valid,
  input  logic                                          out_ready
);
  localparam int unsigned NOUT = IMG_OUT_SIZE * IMG_OUT_SIZE;
  localparam int unsigned KK   = K * K;
  localparam int unsigned ICW  = (IC > 1) ? $clog2(IC) : 1;
  localparam int unsigned OCW  = (OC > 1) ? $clog2(OC) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [ICW-1:0]                  ic_q;
  logic [OCW-1:0]                  oc_q;
  logic                            last_ic, last_oc;
  logic                            acc_clr, acc_add;
  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] cur_img;
  logic [OC-1:0][IC-1:0][KK-1:0]   w_arr;
  logic [KK-1:0]                   cur_w;
  logic signed [ACC_W-1:0]         thr;
  logic [NOUT-1:0]                 out_bits;

  assign last_ic   = (ic_q == ICW'(IC - 1));
  assign last_oc   = (oc_q == OCW'(OC - 1));
  assign busy      = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign acc_clr   = ((state_q == ST_IDLE) && start) || ((state_q == ST_ACCUM) && last_ic);
  assign acc_add   = (state_q == ST_ACCUM) && !last_ic;

  // Packed view puts w[oc][ic][kr*K+kc] at bit ((oc*IC+ic)*K+kr)*K+kc.
  assign w_arr   = weights;
  assign cur_w   = w_arr[oc_q][ic_q];
  assign cur_img = img_in[ic_q];

`ifdef CONV_THRESHOLD_EN
  logic [OC-1:0][ACC_W-1:0] thr_arr;
  assign thr_arr = thresholds;
  assign thr     = $signed(thr_arr[oc_q]);
`else
  logic unused_thresholds;
  assign unused_thresholds = ^thresholds;
  assign thr               = '0;
`endif

  for (genvar p = 0; p < NOUT; p++) begin : g_pix
    localparam int unsigned R = p / IMG_OUT_SIZE;
    localparam int unsigned C = p % IMG_OUT_SIZE;
    logic [KK-1:0]           match;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q;

    for (genvar kr = 0; kr < K; kr++) begin : g_kr
      for (genvar kc = 0; kc < K; kc++) begin : g_kc
        assign match[kr*K+kc] =
          cur_img[(R + kr) * IMG_IN_SIZE + C + kc] ~^ cur_w[kr*K+kc];
      end
    end

    // Each match counts +1, each mismatch -1.
    assign term        = ACC_W'(2 * $countones(match) - int'(KK));
    assign sum         = acc_q + term;
    assign out_bits[p] = (sum >= thr);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        acc_q <= '0;
      end else if (acc_clr) begin
        acc_q <= '0;
      end else if (acc_add) begin
        acc_q <= sum;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ACCUM;
      ST_ACCUM: if (last_ic && last_oc) state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ic_q    <= '0;
      oc_q    <= '0;
      img_out <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        ic_q <= '0;
        oc_q <= '0;
      end else if (state_q == ST_ACCUM) begin
        if (last_ic) begin
          ic_q          <= '0;
          img_out[oc_q] <= out_bits;
          oc_q          <= last_oc ? '0 : oc_q + 1'b1;
        end else begin
          ic_q <= ic_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench: a small 2x2-channel instance for handshake/reset cases and a full-size
// instance checked against a flat match-count model.
module tb_bnn_conv_engine;
  localparam int unsigned S_IC = 2, S_OC = 2, S_IMG = 4, S_OUT = 2, S_ACC_W = 6;
  localparam int unsigned B_IC = 8, B_OC = 4, B_IMG = 30, B_OUT = 28, B_ACC_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                                 s_start, s_busy, s_valid, s_ready;
  logic [S_IC-1:0][S_IMG*S_IMG-1:0]     s_img;
  logic [S_OC*S_IC*9-1:0]               s_w;
  logic [S_OC*S_ACC_W-1:0]              s_thr;
  logic [S_OC-1:0][S_OUT*S_OUT-1:0]     s_out;

  logic                                 b_start, b_busy, b_valid, b_ready;
  logic [B_IC-1:0][B_IMG*B_IMG-1:0]     b_img;
  logic [B_OC*B_IC*9-1:0]               b_w;
  logic [B_OC*B_ACC_W-1:0]              b_thr;
  logic [B_OC-1:0][B_OUT*B_OUT-1:0]     b_out;
  logic [B_OC-1:0][B_OUT*B_OUT-1:0]     exp_big;

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [7:0] exp_t3;

  bnn_conv_engine #(.IC(S_IC), .OC(S_OC), .IMG_IN_SIZE(S_IMG), .K(3)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .img_in(s_img), .weights(s_w),
    .thresholds(s_thr), .busy(s_busy), .img_out(s_out), .out_valid(s_valid),
    .out_ready(s_ready)
  );

  bnn_conv_engine #(.IC(B_IC), .OC(B_OC), .IMG_IN_SIZE(B_IMG), .K(3)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .img_in(b_img), .weights(b_w),
    .thresholds(b_thr), .busy(b_busy), .img_out(b_out), .out_valid(b_valid),
    .out_ready(b_ready)
  );

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic start_small();
    @(negedge clk); s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
  endtask

  task automatic wait_small(output int n);
    n = 0;
    while (!s_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic handshake_small(input string tag);
    s_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, s_valid, 1'b0);
    check({tag, "_idle_busy"}, s_busy, 1'b0);
    s_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    s_start = 1'b0; s_ready = 1'b0; s_img = '0; s_w = '0; s_thr = '0;
    b_start = 1'b0; b_ready = 1'b0; b_img = '0; b_w = '0; b_thr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", s_busy, 1'b0);
    check("rst_valid", s_valid, 1'b0);
    check("rst_out", s_out, 8'h00);
    check("rst_big_out", b_out, '0);
    @(negedge clk) rst = 1'b0;

    // All-zero image and weights: every pixel accumulates +18.
    start_small();
    check("t1_busy", s_busy, 1'b1);
    wait_small(cyc);
    check("t1_latency", cyc, 4);
    check("t1_out", s_out, 8'hFF);
    check("t1_busy_done", s_busy, 1'b0);
    handshake_small("t1");

    // oc1 weights all ones: oc1 accumulates -18.
    s_w = {18'h3FFFF, 18'h00000};
    start_small();
    wait_small(cyc);
    check("t2_latency", cyc, 4);
    check("t2_out", s_out, 8'h0F);
    handshake_small("t2");

    // ic0 all match, ic1 all mismatch: acc 0. Thresholds oc0=1, oc1=0.
    s_w   = {9'h1FF, 9'h000, 9'h1FF, 9'h000};
    s_thr = {6'd0, 6'd1};
`ifdef CONV_THRESHOLD_EN
    exp_t3 = 8'hF0;
`else
    exp_t3 = 8'hFF;
`endif
    start_small();
    wait_small(cyc);
    check("t3_out", s_out, exp_t3);

    // Stall in DONE with start pulses: outputs hold, start is ignored.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) s_start = (i % 2 == 0);
      @(posedge clk); #1;
      check("t4_hold_valid", s_valid, 1'b1);
      check("t4_hold_out", s_out, exp_t3);
    end
    s_start = 1'b0;
    handshake_small("t4");
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_queued_start", s_busy, 1'b0);

    // Reset two cycles into a run, then a fresh run completes.
    s_w = '0;
    start_small();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_out", s_out, 8'h00);
    check("t5_rst_busy", s_busy, 1'b0);
    check("t5_rst_valid", s_valid, 1'b0);
    @(negedge clk) rst = 1'b0;
    s_w = {18'h3FFFF, 18'h00000};
    start_small();
    check("t5_busy", s_busy, 1'b1);
    wait_small(cyc);
    check("t5_latency", cyc, 4);
    check("t5_out", s_out, 8'h0F);
    handshake_small("t5");

    // Full-size run: checkerboard-style maps against a flat match-count model.
    for (int ic = 0; ic < B_IC; ic++)
      for (int r = 0; r < B_IMG; r++)
        for (int c = 0; c < B_IMG; c++)
          b_img[ic][r*B_IMG+c] = (ic < 4) ? 1'((r + c + ic) % 2) : 1'((r/2 + c/2 + ic) % 2);
    for (int oc = 0; oc < B_OC; oc++)
      for (int ic = 0; ic < B_IC; ic++)
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            b_w[((oc*B_IC+ic)*3+kr)*3+kc] = ((oc*5 + ic*3 + kr*2 + kc) % 3 == 0);
    for (int oc = 0; oc < B_OC; oc++) b_thr[oc*B_ACC_W +: B_ACC_W] = 8'(2*oc - 2);
    for (int oc = 0; oc < B_OC; oc++)
      for (int r = 0; r < B_OUT; r++)
        for (int c = 0; c < B_OUT; c++) begin
          int m;
          int acc;
          int th;
          m = 0;
          for (int ic = 0; ic < B_IC; ic++)
            for (int kr = 0; kr < 3; kr++)
              for (int kc = 0; kc < 3; kc++)
                if (b_img[ic][(r+kr)*B_IMG+c+kc] == b_w[((oc*B_IC+ic)*3+kr)*3+kc]) m++;
          acc = 2*m - 72;
`ifdef CONV_THRESHOLD_EN
          th = 2*oc - 2;
`else
          th = 0;
`endif
          exp_big[oc][r*B_OUT+c] = (acc >= th);
        end

    @(negedge clk) b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    check("big_busy", b_busy, 1'b1);
    cyc = 0;
    while (!b_valid && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("big_latency", cyc, 32);
    for (int oc = 0; oc < B_OC; oc++) check($sformatf("big_out_oc%0d", oc), b_out[oc], exp_big[oc]);
    b_ready = 1'b1;
    @(posedge clk); #1;
    check("big_valid_drop", b_valid, 1'b0);
    b_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
